// File: rtl/reg_wb_arb.sv
// Write-back arbiter for the register file write port.
// Merges ALU results with FIFO-buffered load returns; also reports pending writes for hazard checks.
module reg_wb_arb #(
  parameter int PW     = 4,
  parameter int DW     = 8,
  parameter int DEPTH  = 4,
  parameter int STARVE = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [PW:0]              alu_addr,
  input  logic [DW-1:0]            alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [PW:0]              ld_addr,
  input  logic [DW-1:0]            ld_data,
  input  logic [PW:0]              hz_addr,
  output logic                     hz_hit,
  output logic                     wr_en,
  output logic [PW:0]              wr_addr,
  output logic [DW-1:0]            dat_in,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     order_err,
  output logic                     addr_err
);

  localparam int AW = PW + 1;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int SW = $clog2(STARVE + 1);
  localparam logic [AW-1:0] MAX_ADDR = AW'(2 ** PW);

  logic [AW-1:0]    mem_addr [DEPTH];
  logic [DW-1:0]    mem_data [DEPTH];
  logic [DEPTH-1:0] mem_vld;
  logic [IW-1:0]    rd_ptr;
  logic [IW-1:0]    wr_ptr;
  logic [SW-1:0]    starve_cnt;
  logic             armed;

  logic             empty;
  logic             full;
  logic             force_pop;
  logic             alu_acc;
  logic             pop;
  logic             push;
  logic             grant;
  logic             addr_ok;
  logic             order_hit;
  logic [AW-1:0]    grant_addr;
  logic [DW-1:0]    grant_data;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign force_pop = !empty && (starve_cnt == SW'(STARVE));

  // armed stays low for the first cycle after reset release so no write issues on that edge
  assign alu_ready = !rst_n || (armed && !force_pop);
  assign ld_ready  = !full;

  assign alu_acc   = alu_valid && armed && !force_pop;
  assign pop       = armed && !empty && (force_pop || !alu_valid);
  assign push      = ld_valid && !full;
  assign grant     = alu_acc || pop;

  assign grant_addr = alu_acc ? alu_addr : mem_addr[rd_ptr];
  assign grant_data = alu_acc ? alu_data : mem_data[rd_ptr];
  assign addr_ok    = (grant_addr <= MAX_ADDR);

  always_comb begin
    order_hit = 1'b0;
    hz_hit    = wr_en && (wr_addr == hz_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_vld[i] && (mem_addr[i] == alu_addr)) order_hit = 1'b1;
      if (mem_vld[i] && (mem_addr[i] == hz_addr))  hz_hit    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      mem_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (pop) begin
        mem_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + IW'(1);
      end
      if (push) begin
        mem_vld[wr_ptr]  <= 1'b1;
        mem_addr[wr_ptr] <= ld_addr;
        mem_data[wr_ptr] <= ld_data;
        wr_ptr           <= wr_ptr + IW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Age of the FIFO head while the ALU keeps winning; saturates at the force threshold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Out-of-range writes are consumed but never reach the register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      dat_in  <= '0;
    end else if (grant && addr_ok) begin
      wr_en   <= 1'b1;
      wr_addr <= grant_addr;
      dat_in  <= grant_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_err <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      if (alu_acc && order_hit) order_err <= 1'b1;
      if (grant && !addr_ok)    addr_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_wb_arb.sv
// Self-checking bench for reg_wb_arb: ALU vector table, load/arbitration sequences and a
// scoreboard of expected register-file writes in issue order.
module tb_reg_wb_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alu_valid = 1'b0;
  logic       alu_ready;
  logic [4:0] alu_addr = '0;
  logic [7:0] alu_data = '0;
  logic       ld_valid = 1'b0;
  logic       ld_ready;
  logic [4:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [4:0] hz_addr = '0;
  logic       hz_hit;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] dat_in;
  logic [2:0] count;
  logic       order_err;
  logic       addr_err;

  int checks = 0;
  int errors = 0;
  logic [12:0] sb [$];
  logic [12:0] mon_exp;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    logic       exp_wr;
    logic       exp_aerr;
  } vec_t;

  vec_t tbl [7];

  reg_wb_arb #(.PW(4), .DW(8), .DEPTH(4), .STARVE(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .hz_addr(hz_addr), .hz_hit(hz_hit),
    .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .count(count), .order_err(order_err), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [7:0] ad,
                               input logic lv, input logic [4:0] la, input logic [7:0] ld);
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    ld_valid  = lv;
    ld_addr   = la;
    ld_data   = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Every issued write must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL wr_unexpected got %0h want none", {wr_addr, dat_in});
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("wr_seq", 32'({wr_addr, dat_in}), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int maxcnt;
    int idx;
    logic [7:0] d;

    tbl[0] = '{5'd5,  8'h3C, 1'b1, 1'b0};
    tbl[1] = '{5'd0,  8'h01, 1'b1, 1'b0};
    tbl[2] = '{5'd16, 8'hA5, 1'b1, 1'b0};
    tbl[3] = '{5'd15, 8'h5A, 1'b1, 1'b0};
    tbl[4] = '{5'd17, 8'h77, 1'b0, 1'b1};
    tbl[5] = '{5'd3,  8'h33, 1'b1, 1'b1};
    tbl[6] = '{5'd20, 8'hEE, 1'b0, 1'b1};

    // reset state
    tick();
    tick();
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_dat_in", 32'(dat_in), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("rst_ld_ready", 32'(ld_ready), 32'd1);
    checkOutput("rst_errs", 32'({order_err, addr_err}), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // single ALU writes, including address boundary 16/17
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, tbl[i].addr, tbl[i].data, 1'b0, 5'd0, 8'd0);
      settle();
      checkOutput($sformatf("tbl%0d_alu_ready", i), 32'(alu_ready), 32'd1);
      if (tbl[i].exp_wr) sb.push_back({tbl[i].addr, tbl[i].data});
      tick();
      applyStimulus(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0);
      checkOutput($sformatf("tbl%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].exp_wr));
      if (tbl[i].exp_wr) begin
        checkOutput($sformatf("tbl%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].addr));
        checkOutput($sformatf("tbl%0d_dat_in", i), 32'(dat_in), 32'(tbl[i].data));
      end
      checkOutput($sformatf("tbl%0d_addr_err", i), 32'(addr_err), 32'(tbl[i].exp_aerr));
      tick();
      checkOutput($sformatf("tbl%0d_wr_idle", i), 32'(wr_en), 32'd0);
    end

    // back-to-back loads with ALU idle
    maxcnt = 0;
    for (int k = 0; k < 4; k++) begin
      d = 8'(17 * (k + 1));
      applyStimulus(1'b0, 5'd0, 8'd0, 1'b1, 5'(k + 1), d);
      sb.push_back({5'(k + 1), d});
      settle();
      checkOutput($sformatf("t2_ld_ready%0d", k), 32'(ld_ready), 32'd1);
      tick();
      if (int'(count) > maxcnt) maxcnt = int'(count);
      if (k == 0) checkOutput("t2_lat_n1", 32'(wr_en), 32'd0);
      if (k == 1) checkOutput("t2_lat_n2", 32'({wr_en, wr_addr}), 32'({1'b1, 5'd1}));
    end
    applyStimulus(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0);
    tick();
    tick();
    checkOutput("t2_max_count", 32'(maxcnt), 32'd1);
    checkOutput("t2_drained", 32'(count), 32'd0);

    // ALU flood starves one load; forced drain then the held ALU value
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      d = 8'hA0 + 8'(idx);
      applyStimulus(1'b1, 5'd9, d, k == 0, 5'd7, 8'h77);
      settle();
      checkOutput($sformatf("t3_alu_ready%0d", k), 32'(alu_ready), 32'(k != 4));
      if (k == 4) begin
        sb.push_back({5'd7, 8'h77});
      end else begin
        sb.push_back({5'd9, d});
        idx++;
      end
      tick();
    end
    applyStimulus(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0);
    tick();
    tick();

    // fill FIFO under ALU flood, then push+pop at count 3
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 5'd9, 8'hB0 + 8'(k), 1'b1, 5'(10 + k), 8'hC0 + 8'(k));
      settle();
      checkOutput($sformatf("t4_ld_ready%0d", k), 32'(ld_ready), 32'd1);
      sb.push_back({5'd9, 8'hB0 + 8'(k)});
      tick();
    end
    checkOutput("t4_count_full", 32'(count), 32'd4);
    applyStimulus(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0);
    settle();
    checkOutput("t4_ld_ready_full", 32'(ld_ready), 32'd0);
    checkOutput("t4_alu_ready_force", 32'(alu_ready), 32'd0);
    sb.push_back({5'd10, 8'hC0});
    tick();
    checkOutput("t4_count_after_force", 32'(count), 32'd3);
    applyStimulus(1'b0, 5'd0, 8'd0, 1'b1, 5'd14, 8'hC4);
    sb.push_back({5'd11, 8'hC1});
    settle();
    checkOutput("t4_ld_ready_cnt3", 32'(ld_ready), 32'd1);
    tick();
    checkOutput("t4_count_pushpop", 32'(count), 32'd3);
    applyStimulus(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0);
    sb.push_back({5'd12, 8'hC2});
    sb.push_back({5'd13, 8'hC3});
    sb.push_back({5'd14, 8'hC4});
    for (int k = 0; k < 4; k++) tick();
    checkOutput("t4_drained", 32'(count), 32'd0);

    // ordering error and hazard lookup
    checkOutput("t5_order_clear", 32'(order_err), 32'd0);
    applyStimulus(1'b0, 5'd0, 8'd0, 1'b1, 5'd2, 8'h22);
    tick();
    applyStimulus(1'b1, 5'd2, 8'h99, 1'b0, 5'd0, 8'd0);
    hz_addr = 5'd2;
    settle();
    checkOutput("t5_hz_fifo", 32'(hz_hit), 32'd1);
    sb.push_back({5'd2, 8'h99});
    hz_addr = 5'd3;
    settle();
    checkOutput("t5_hz_miss", 32'(hz_hit), 32'd0);
    hz_addr = 5'd2;
    tick();
    checkOutput("t5_order_set", 32'(order_err), 32'd1);
    applyStimulus(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0);
    settle();
    checkOutput("t5_hz_pending", 32'(hz_hit), 32'd1);
    sb.push_back({5'd2, 8'h22});
    tick();
    checkOutput("t5_hz_issuing", 32'(hz_hit), 32'd1);
    tick();
    checkOutput("t5_hz_retired", 32'(hz_hit), 32'd0);
    checkOutput("t5_order_sticky", 32'(order_err), 32'd1);
    hz_addr = 5'd0;

    // reset with two loads queued
    applyStimulus(1'b1, 5'd6, 8'h61, 1'b1, 5'd8, 8'h81);
    sb.push_back({5'd6, 8'h61});
    tick();
    applyStimulus(1'b1, 5'd6, 8'h62, 1'b1, 5'd9, 8'h91);
    tick();
    checkOutput("t6_count_pre", 32'(count), 32'd2);
    checkOutput("t6_wr_pre", 32'(wr_en), 32'd1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0);
    settle();
    checkOutput("t6_count_rst", 32'(count), 32'd0);
    checkOutput("t6_wr_rst", 32'(wr_en), 32'd0);
    checkOutput("t6_readies_rst", 32'({alu_ready, ld_ready}), 32'd3);
    checkOutput("t6_errs_rst", 32'({order_err, addr_err}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 5'd3, 8'h55, 1'b0, 5'd0, 8'd0);
    sb.push_back({5'd3, 8'h55});
    tick();
    checkOutput("t6_first_edge", 32'(wr_en), 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 8'd0);
    checkOutput("t6_post_rst_wr", 32'({wr_en, wr_addr, dat_in}), 32'({1'b1, 5'd3, 8'h55}));

    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    tick();
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
